// File: rtl/axis_pkt_buffer.sv
// AXI-Stream single-packet buffer drained through a read-strobed port.
// Define AXIS_PKTBUF_DROP_OVERSIZE_EN to drop oversized packets instead of truncating.
module axis_pkt_buffer #(
   parameter  int DATA_WIDTH = 32,
   parameter  int DEPTH      = 16,
   localparam int LEN_W      = $clog2(DEPTH + 1)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [DATA_WIDTH-1:0] s_axis_tdata,
   input  logic                  s_axis_tvalid,
   input  logic                  s_axis_tlast,
   output logic                  s_axis_tready,
   input  logic                  read,
   output logic [DATA_WIDTH-1:0] dout,
   output logic                  dout_valid,
   output logic                  done,
   output logic [LEN_W-1:0]      pkt_len,
   output logic                  overflow
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   typedef enum logic [1:0] {
      IDLE,
      CAPTURE,
      DISCARD,
      DRAIN
   } state_t;

   state_t                state_q, state_d;
   logic [LEN_W-1:0]      wr_cnt_q, wr_cnt_d;
   logic [LEN_W-1:0]      rd_ptr_q, rd_ptr_d;
   logic                  tready_q;
   logic [DATA_WIDTH-1:0] dout_q;
   logic                  dout_valid_q;
   logic                  ovf_q, ovf_d;
   logic                  wr_en, rd_en, beat;
   logic [AW-1:0]         wr_idx, rd_idx;
   logic [DATA_WIDTH-1:0] mem [DEPTH];

   assign beat   = s_axis_tvalid & tready_q;
   assign wr_idx = (state_q == IDLE) ? '0 : wr_cnt_q[AW-1:0];
   assign rd_idx = rd_ptr_q[AW-1:0];

   always_comb begin
      state_d  = state_q;
      wr_cnt_d = wr_cnt_q;
      rd_ptr_d = rd_ptr_q;
      wr_en    = 1'b0;
      rd_en    = 1'b0;
      ovf_d    = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (beat) begin
               wr_en    = 1'b1;
               wr_cnt_d = LEN_W'(1);
               state_d  = s_axis_tlast ? DRAIN : CAPTURE;
            end
         end
         CAPTURE: begin
            if (beat) begin
               wr_en    = 1'b1;
               wr_cnt_d = wr_cnt_q + LEN_W'(1);
               if (s_axis_tlast)
                  state_d = DRAIN;
               else if (wr_cnt_q == LEN_W'(DEPTH - 1))
                  state_d = DISCARD;
            end
         end
         DISCARD: begin
            if (beat && s_axis_tlast) begin
               ovf_d = 1'b1;
`ifdef AXIS_PKTBUF_DROP_OVERSIZE_EN
               state_d  = IDLE;
               wr_cnt_d = '0;
`else
               state_d  = DRAIN;
`endif
            end
         end
         DRAIN: begin
            if (read) begin
               rd_en = 1'b1;
               if (rd_ptr_q == wr_cnt_q - LEN_W'(1)) begin
                  state_d  = IDLE;
                  wr_cnt_d = '0;
                  rd_ptr_d = '0;
               end else begin
                  rd_ptr_d = rd_ptr_q + LEN_W'(1);
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q      <= IDLE;
         wr_cnt_q     <= '0;
         rd_ptr_q     <= '0;
         tready_q     <= 1'b0;
         dout_q       <= '0;
         dout_valid_q <= 1'b0;
         ovf_q        <= 1'b0;
      end else begin
         state_q      <= state_d;
         wr_cnt_q     <= wr_cnt_d;
         rd_ptr_q     <= rd_ptr_d;
         tready_q     <= (state_d != DRAIN);
         dout_valid_q <= rd_en;
         ovf_q        <= ovf_d;
         if (rd_en)
            dout_q <= mem[rd_idx];
      end
   end

   // Storage needs no reset: only written locations are ever read back.
   always_ff @(posedge clk) begin
      if (wr_en)
         mem[wr_idx] <= s_axis_tdata;
   end

   assign s_axis_tready = tready_q;
   assign dout          = dout_q;
   assign dout_valid    = dout_valid_q;
   assign done          = (state_q == DRAIN);
   assign pkt_len       = (state_q == DRAIN) ? wr_cnt_q : '0;
   assign overflow      = ovf_q;

endmodule

// File: tb/tb_axis_pkt_buffer.sv
// Randomized self-checking bench for axis_pkt_buffer with DEPTH=4.
// Expected traffic comes from a packet-level model of the buffer's rules.
module tb_axis_pkt_buffer;

   localparam int DW    = 32;
   localparam int DEPTH = 4;
   localparam int LEN_W = $clog2(DEPTH + 1);
`ifdef AXIS_PKTBUF_DROP_OVERSIZE_EN
   localparam bit DROP = 1'b1;
`else
   localparam bit DROP = 1'b0;
`endif

   logic             clk = 1'b0;
   logic             rst = 1'b0;
   logic [DW-1:0]    s_axis_tdata = '0;
   logic             s_axis_tvalid = 1'b0;
   logic             s_axis_tlast = 1'b0;
   logic             s_axis_tready;
   logic             read = 1'b0;
   logic [DW-1:0]    dout;
   logic             dout_valid;
   logic             done;
   logic [LEN_W-1:0] pkt_len;
   logic             overflow;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   axis_pkt_buffer #(
      .DATA_WIDTH(DW),
      .DEPTH     (DEPTH)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .s_axis_tdata (s_axis_tdata),
      .s_axis_tvalid(s_axis_tvalid),
      .s_axis_tlast (s_axis_tlast),
      .s_axis_tready(s_axis_tready),
      .read         (read),
      .dout         (dout),
      .dout_valid   (dout_valid),
      .done         (done),
      .pkt_len      (pkt_len),
      .overflow     (overflow)
   );

   task automatic step;
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs;
      s_axis_tvalid = 1'b0;
      s_axis_tlast  = 1'b0;
      s_axis_tdata  = '0;
      read          = 1'b0;
   endtask

   // Streams the given packets, pulls words whenever done, and compares
   // everything delivered against the packet-level expectation.
   task automatic run_stream(input string name, input int lens[$],
                             input logic [DW-1:0] beats[$], input bit gaps);
      logic [DW-1:0] exp_w[$];
      logic [DW-1:0] got_w[$];
      int            exp_l[$];
      int            got_l[$];
      bit            last_q[$];
      int            exp_ovf, got_ovf, pos, idx, cyc, bad_hs, bad_dv, done_cyc, n, nw;
      bit            prev_rd, prev_done, acc;
      exp_ovf = 0; got_ovf = 0; pos = 0; idx = 0; cyc = 0;
      bad_hs = 0; bad_dv = 0; done_cyc = 0;
      foreach (lens[p]) begin
         n = lens[p];
         if (n > DEPTH) exp_ovf++;
         if (!(n > DEPTH && DROP)) begin
            exp_l.push_back(n > DEPTH ? DEPTH : n);
            for (int k = 0; k < n && k < DEPTH; k++)
               exp_w.push_back(beats[pos + k]);
         end
         for (int k = 0; k < n; k++)
            last_q.push_back(k == n - 1);
         pos += n;
      end
      while (1) begin
         if (idx < beats.size()) begin
            s_axis_tvalid = !gaps || ($urandom_range(0, 2) != 0);
            s_axis_tdata  = beats[idx];
            s_axis_tlast  = last_q[idx];
         end else begin
            s_axis_tvalid = 1'b0;
            s_axis_tdata  = '0;
            s_axis_tlast  = 1'b0;
         end
         read      = done && (!gaps || ($urandom_range(0, 2) != 0));
         acc       = s_axis_tvalid && s_axis_tready;
         prev_rd   = read;
         prev_done = done;
         step;
         cyc++;
         if (acc) idx++;
         if (dout_valid) got_w.push_back(dout);
         if (dout_valid !== (prev_rd && prev_done)) bad_dv++;
         if (overflow) got_ovf++;
         if (done) done_cyc++;
         if (done && !prev_done) got_l.push_back(int'(pkt_len));
         if (s_axis_tready !== !done) bad_hs++;
         if ((idx == beats.size() && !done) || cyc > 2000) break;
      end
      idle_inputs();
      step;
      checks++;
      if (cyc > 2000) begin
         errors++;
         $display("FAIL %s timeout: cycles %0d required <= 2000", name, cyc);
      end
      checks++;
      if (got_w.size() != exp_w.size()) begin
         errors++;
         $display("FAIL %s word_count: got %0d required %0d", name, got_w.size(), exp_w.size());
      end
      nw = (got_w.size() < exp_w.size()) ? got_w.size() : exp_w.size();
      for (int i = 0; i < nw; i++) begin
         checks++;
         if (got_w[i] !== exp_w[i]) begin
            errors++;
            $display("FAIL %s word[%0d]: got %h required %h", name, i, got_w[i], exp_w[i]);
         end
      end
      checks++;
      if (got_l != exp_l) begin
         errors++;
         $display("FAIL %s pkt_len: got %p required %p", name, got_l, exp_l);
      end
      checks++;
      if (got_ovf != exp_ovf) begin
         errors++;
         $display("FAIL %s overflow_pulses: got %0d required %0d", name, got_ovf, exp_ovf);
      end
      checks++;
      if (bad_hs != 0) begin
         errors++;
         $display("FAIL %s tready_vs_done: got %0d bad cycles required 0", name, bad_hs);
      end
      checks++;
      if (bad_dv != 0) begin
         errors++;
         $display("FAIL %s dout_valid_latency: got %0d bad cycles required 0", name, bad_dv);
      end
      if (!gaps) begin
         checks++;
         if (done_cyc != exp_w.size()) begin
            errors++;
            $display("FAIL %s drain_cycles: got %0d required %0d", name, done_cyc, exp_w.size());
         end
      end
   endtask

   task automatic test_reset;
      rst = 1'b0;
      idle_inputs();
      repeat (3) step;
      checks++;
      if ({s_axis_tready, dout_valid, done, overflow} !== 4'b0000) begin
         errors++;
         $display("FAIL reset_flags: got %b required 0000",
                  {s_axis_tready, dout_valid, done, overflow});
      end
      checks++;
      if (dout !== '0) begin
         errors++;
         $display("FAIL reset_dout: got %h required 0", dout);
      end
      checks++;
      if (pkt_len !== '0) begin
         errors++;
         $display("FAIL reset_pkt_len: got %0d required 0", pkt_len);
      end
      rst = 1'b1;
      step;
      checks++;
      if (s_axis_tready !== 1'b1) begin
         errors++;
         $display("FAIL reset_release_tready: got %b required 1", s_axis_tready);
      end
   endtask

   task automatic test_basic;
      logic [DW-1:0] d[3];
      d[0] = 32'h11; d[1] = 32'h22; d[2] = 32'h33;
      for (int i = 0; i < 3; i++) begin
         s_axis_tvalid = 1'b1;
         s_axis_tdata  = d[i];
         s_axis_tlast  = (i == 2);
         step;
      end
      idle_inputs();
      checks++;
      if ({done, s_axis_tready} !== 2'b10 || pkt_len !== LEN_W'(3)) begin
         errors++;
         $display("FAIL basic_stored: got done=%b tready=%b len=%0d required 1 0 3",
                  done, s_axis_tready, pkt_len);
      end
      read = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step;
         checks++;
         if (dout_valid !== 1'b1 || dout !== d[i]) begin
            errors++;
            $display("FAIL basic_read%0d: got v=%b %h required v=1 %h", i, dout_valid, dout, d[i]);
         end
         checks++;
         if (done !== (i < 2) || s_axis_tready !== (i == 2)) begin
            errors++;
            $display("FAIL basic_done%0d: got done=%b tready=%b required %b %b",
                     i, done, s_axis_tready, i < 2, i == 2);
         end
      end
      read = 1'b0;
      step;
      checks++;
      if (dout_valid !== 1'b0 || dout !== d[2]) begin
         errors++;
         $display("FAIL basic_hold: got v=%b %h required v=0 %h", dout_valid, dout, d[2]);
      end
      read = 1'b1;
      step;
      read = 1'b0;
      checks++;
      if (dout_valid !== 1'b0 || dout !== d[2]) begin
         errors++;
         $display("FAIL idle_read: got v=%b %h required v=0 %h", dout_valid, dout, d[2]);
      end
   endtask

   task automatic test_zero;
      int            l[$];
      logic [DW-1:0] b[$];
      l.push_back(3);
      b.push_back(32'h0); b.push_back(32'h0); b.push_back(32'h5);
      run_stream("zero_data", l, b, 1'b0);
   endtask

   task automatic test_oversize;
      int            l[$];
      logic [DW-1:0] b[$];
      l.push_back(6);
      for (int i = 0; i < 6; i++) b.push_back(DW'(32'hA0 + i));
      l.push_back(2);
      b.push_back(32'h51); b.push_back(32'h52);
      run_stream("oversize", l, b, 1'b0);
   endtask

   task automatic test_exact;
      int            l[$];
      logic [DW-1:0] b[$];
      l.push_back(DEPTH);
      for (int i = 0; i < DEPTH; i++) b.push_back(DW'(32'hC0 + i));
      l.push_back(DEPTH + 1);
      for (int i = 0; i <= DEPTH; i++) b.push_back(DW'(32'hD0 + i));
      run_stream("exact_and_plus1", l, b, 1'b0);
   endtask

   task automatic test_back_to_back;
      int            l[$];
      logic [DW-1:0] b[$];
      for (int p = 0; p < 3; p++) begin
         l.push_back(p + 1);
         for (int i = 0; i <= p; i++) b.push_back($urandom);
      end
      run_stream("back_to_back", l, b, 1'b0);
   endtask

   task automatic test_random;
      int            l[$];
      logic [DW-1:0] b[$];
      int            n;
      for (int it = 0; it < 16; it++) begin
         l.delete();
         b.delete();
         for (int p = 0; p < int'($urandom_range(1, 3)); p++) begin
            n = $urandom_range(1, DEPTH + 2);
            l.push_back(n);
            for (int i = 0; i < n; i++)
               b.push_back(($urandom_range(0, 3) == 0) ? '0 : DW'($urandom));
         end
         run_stream($sformatf("random%0d", it), l, b, it[0]);
      end
   endtask

   task automatic test_reset_mid;
      int            l[$];
      logic [DW-1:0] b[$];
      for (int i = 0; i < 3; i++) begin
         s_axis_tvalid = 1'b1;
         s_axis_tdata  = DW'(32'hE0 + i);
         s_axis_tlast  = (i == 2);
         step;
      end
      idle_inputs();
      read = 1'b1;
      repeat (2) step;
      read = 1'b0;
      rst  = 1'b0;
      step;
      checks++;
      if ({s_axis_tready, dout_valid, done, overflow} !== 4'b0000 ||
          dout !== '0 || pkt_len !== '0) begin
         errors++;
         $display("FAIL mid_reset: got tr=%b v=%b done=%b ovf=%b dout=%h len=%0d required all 0",
                  s_axis_tready, dout_valid, done, overflow, dout, pkt_len);
      end
      rst = 1'b1;
      step;
      checks++;
      if (s_axis_tready !== 1'b1 || done !== 1'b0) begin
         errors++;
         $display("FAIL mid_reset_release: got tr=%b done=%b required 1 0", s_axis_tready, done);
      end
      l.push_back(1);
      b.push_back(32'h7);
      run_stream("after_reset", l, b, 1'b0);
   endtask

   initial begin
      test_reset();
      test_basic();
      test_zero();
      test_oversize();
      test_exact();
      test_back_to_back();
      test_random();
      test_reset_mid();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
